// File: rtl/vga_text_console.sv
// vga_text_console: terminal-style byte sequencer driving the VGA text controller's cell write port
module vga_text_console #(
  parameter int          COLS           = 64,
  parameter int          ROWS           = 24,
  parameter logic [7:0]  CLEAR_CODE     = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_code,
  output logic        in_ready,
  input  logic        set_color,
  input  logic [23:0] color_fg,
  input  logic [23:0] color_bg,
  output logic        charWr,
  output logic [23:0] charWrFgColor,
  output logic [23:0] charWrBgColor,
  output logic [7:0]  charWrCode,
  output logic [5:0]  charWrX,
  output logic [4:0]  charWrY,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_SCREEN} state_t;
  localparam logic [5:0] X_MAX = 6'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR_SCREEN : IDLE;
  state_t      state_q, state_d;
  logic [5:0]  cx_q, cx_d, clr_x_q, clr_x_d, wr_x_q, wr_x_d;
  logic [4:0]  cy_q, cy_d, clr_y_q, clr_y_d, wr_y_q, wr_y_d, y_inc;
  logic [23:0] fg_q, fg_d, bg_q, bg_d, wr_fg_q, wr_fg_d, wr_bg_q, wr_bg_d;
  logic [7:0]  wr_code_q, wr_code_d;
  logic        wr_q, wr_d;
  assign in_ready      = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign charWr        = wr_q;
  assign charWrFgColor = wr_fg_q;
  assign charWrBgColor = wr_bg_q;
  assign charWrCode    = wr_code_q;
  assign charWrX       = wr_x_q;
  assign charWrY       = wr_y_q;
  assign cursor_x      = cx_q;
  assign cursor_y      = cy_q;
  assign y_inc         = cy_q == Y_MAX ? 5'd0 : cy_q + 5'd1;
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    fg_d      = set_color ? color_fg : fg_q;
    bg_d      = set_color ? color_bg : bg_q;
    wr_d      = 1'b0;
    wr_code_d = wr_code_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_fg_d   = wr_fg_q;
    wr_bg_d   = wr_bg_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (in_code >= 8'h20) begin
          wr_d      = 1'b1;
          wr_code_d = in_code;
          wr_x_d    = cx_q;
          wr_y_d    = cy_q;
          wr_fg_d   = fg_d;
          wr_bg_d   = bg_d;
          cx_d      = cx_q == X_MAX ? 6'd0 : cx_q + 6'd1;
          if (cx_q == X_MAX) begin
            cy_d    = y_inc;
            clr_x_d = 6'd0;
            state_d = CLEAR_LINE;
          end
        end else if (in_code == 8'h0D) begin
          cx_d = 6'd0;
        end else if (in_code == 8'h0A) begin
          cx_d    = 6'd0;
          cy_d    = y_inc;
          clr_x_d = 6'd0;
          state_d = CLEAR_LINE;
        end else if (in_code == 8'h08 && cx_q != 6'd0) begin
          wr_d      = 1'b1;
          wr_code_d = CLEAR_CODE;
          wr_x_d    = cx_q - 6'd1;
          wr_y_d    = cy_q;
          wr_fg_d   = fg_d;
          wr_bg_d   = bg_d;
          cx_d      = cx_q - 6'd1;
        end else if (in_code == 8'h0C) begin
          cx_d    = 6'd0;
          cy_d    = 5'd0;
          clr_x_d = 6'd0;
          clr_y_d = 5'd0;
          state_d = CLEAR_SCREEN;
        end
      end
      CLEAR_LINE: begin
        wr_d      = 1'b1;
        wr_code_d = CLEAR_CODE;
        wr_x_d    = clr_x_q;
        wr_y_d    = cy_q;
        wr_fg_d   = fg_d;
        wr_bg_d   = bg_d;
        clr_x_d   = clr_x_q == X_MAX ? 6'd0 : clr_x_q + 6'd1;
        state_d   = clr_x_q == X_MAX ? IDLE : CLEAR_LINE;
      end
      CLEAR_SCREEN: begin
        wr_d      = 1'b1;
        wr_code_d = CLEAR_CODE;
        wr_x_d    = clr_x_q;
        wr_y_d    = clr_y_q;
        wr_fg_d   = fg_d;
        wr_bg_d   = bg_d;
        clr_x_d   = clr_x_q == X_MAX ? 6'd0 : clr_x_q + 6'd1;
        if (clr_x_q == X_MAX) begin
          clr_y_d = clr_y_q == Y_MAX ? 5'd0 : clr_y_q + 5'd1;
          state_d = clr_y_q == Y_MAX ? IDLE : CLEAR_SCREEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q   <= RESET_STATE;
      cx_q      <= '0;
      cy_q      <= '0;
      clr_x_q   <= '0;
      clr_y_q   <= '0;
      fg_q      <= 24'hFFFFFF;
      bg_q      <= '0;
      wr_q      <= 1'b0;
      wr_code_q <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_fg_q   <= '0;
      wr_bg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      wr_q      <= wr_d;
      wr_code_q <= wr_code_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_fg_q   <= wr_fg_d;
      wr_bg_q   <= wr_bg_d;
    end
endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: randomized bench comparing captured cell writes against a terminal model
module tb_vga_text_console;
  typedef struct packed {
    logic [7:0]  code;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [23:0] fg;
    logic [23:0] bg;
  } wr_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_code = 8'h00;
  logic        in_ready;
  logic        set_color = 1'b0;
  logic [23:0] color_fg = 24'h0;
  logic [23:0] color_bg = 24'h0;
  logic        charWr;
  logic [23:0] charWrFgColor, charWrBgColor;
  logic [7:0]  charWrCode;
  logic [5:0]  charWrX, cursor_x;
  logic [4:0]  charWrY, cursor_y;
  logic        busy;

  vga_text_console dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .set_color(set_color), .color_fg(color_fg), .color_bg(color_bg),
    .charWr(charWr), .charWrFgColor(charWrFgColor), .charWrBgColor(charWrBgColor),
    .charWrCode(charWrCode), .charWrX(charWrX), .charWrY(charWrY),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  wr_t got_q[$], exp_q[$];
  int  stamp_q[$];
  int  mx = 0, my = 0;
  logic [23:0] mfg = 24'hFFFFFF, mbg = 24'h0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50)
    if (!reset && charWr) begin
      got_q.push_back(wr_t'{charWrCode, charWrX, charWrY, charWrFgColor, charWrBgColor});
      stamp_q.push_back(cyc);
    end

  // Terminal model: cursor arithmetic on plain ints, writes listed in issue order
  task automatic push_row(input int y);
    for (int x = 0; x < 64; x++) exp_q.push_back(wr_t'{8'h20, 6'(x), 5'(y), mfg, mbg});
  endtask
  task automatic push_screen();
    for (int y = 0; y < 24; y++) push_row(y);
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20) begin
      exp_q.push_back(wr_t'{b, 6'(mx), 5'(my), mfg, mbg});
      mx = mx + 1;
      if (mx == 64) begin mx = 0; my = (my + 1) % 24; push_row(my); end
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h0A) begin mx = 0; my = (my + 1) % 24; push_row(my); end
    else if (b == 8'h08) begin
      if (mx > 0) begin mx = mx - 1; exp_q.push_back(wr_t'{8'h20, 6'(mx), 5'(my), mfg, mbg}); end
    end else if (b == 8'h0C) begin mx = 0; my = 0; push_screen(); end
  endtask

  task automatic send(input logic [7:0] b, input bit sc = 1'b0,
                      input logic [23:0] fg = 24'h0, input logic [23:0] bg = 24'h0);
    int n = 0;
    while (!in_ready && n < 3000) begin n++; @(negedge CLOCK_50); end
    if (n >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout in_ready stuck low, byte %h", b);
    end
    if (sc) begin mfg = fg; mbg = bg; end
    model_byte(b);
    in_valid = 1'b1; in_code = b; set_color = sc; color_fg = fg; color_bg = bg;
    @(negedge CLOCK_50);
    in_valid = 1'b0; set_color = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge CLOCK_50);
    while (!in_ready && n < 3000) begin n++; @(negedge CLOCK_50); end
    if (n >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout in_ready stuck low");
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    n_cmp++;
    if ({charWr, charWrCode, charWrX, charWrY, charWrFgColor, charWrBgColor} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got wr=%b code=%h x=%0d y=%0d fg=%h bg=%h want all 0",
               charWr, charWrCode, charWrX, charWrY, charWrFgColor, charWrBgColor);
    end
    n_cmp++;
    if ({cursor_x, cursor_y, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_cursor got (%0d,%0d) rdy=%b want (0,0) rdy=0", cursor_x, cursor_y, in_ready);
    end
    push_screen();
    reset = 1'b0;
    wait_idle();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_cmp++;
    if (got_q.size() != exp_q.size() || stamp_q[$] - stamp_q[0] != 1535) begin
      n_fail++;
      $display("FAIL reset_count got %0d writes over %0d cycles want 1536 over 1535",
               got_q.size(), stamp_q[$] - stamp_q[0]);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
  endtask

  task automatic test_stream_ab();
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    send(8'h41); send(8'h42);
    wait_idle();
    n_cmp++;
    if (got_q.size() != 2 || stamp_q[1] - stamp_q[0] != 1) begin
      n_fail++;
      $display("FAIL ab_timing got %0d writes gap %0d want 2 gap 1", got_q.size(), stamp_q[1] - stamp_q[0]);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ab_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
    n_cmp++;
    if (cursor_x !== 6'(mx) || cursor_y !== 5'(my)) begin
      n_fail++;
      $display("FAIL ab_cursor got (%0d,%0d) want (%0d,%0d)", cursor_x, cursor_y, mx, my);
    end
  endtask

  task automatic test_wrap();
    int low = 0;
    send(8'h0D);
    repeat (5) send(8'h0A);
    repeat (63) send(8'($urandom_range(8'h21, 8'h7E)));
    wait_idle();
    n_cmp++;
    if (cursor_x !== 6'd63 || cursor_y !== 5'd5) begin
      n_fail++;
      $display("FAIL wrap_pre_cursor got (%0d,%0d) want (63,5)", cursor_x, cursor_y);
    end
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    send(8'($urandom_range(8'h21, 8'h7E)));
    while (!in_ready && low < 200) begin low++; @(negedge CLOCK_50); end
    @(negedge CLOCK_50);
    n_cmp++;
    if (low != 64) begin n_fail++; $display("FAIL wrap_ready_low got %0d cycles want 64", low); end
    n_cmp++;
    if (got_q.size() != 65 || stamp_q[$] - stamp_q[0] != 64) begin
      n_fail++;
      $display("FAIL wrap_gap got %0d writes span %0d want 65 span 64", got_q.size(), stamp_q[$] - stamp_q[0]);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
    n_cmp++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd6) begin
      n_fail++;
      $display("FAIL wrap_cursor got (%0d,%0d) want (0,6)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_lf_bs();
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    repeat (17) send(8'h0A);
    repeat (10) send(8'($urandom_range(8'h20, 8'hFF)));
    wait_idle();
    n_cmp++;
    if (cursor_x !== 6'd10 || cursor_y !== 5'd23) begin
      n_fail++;
      $display("FAIL lf_pre_cursor got (%0d,%0d) want (10,23)", cursor_x, cursor_y);
    end
    send(8'h0A);
    wait_idle();
    n_cmp++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL lf_wrap_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    send(8'h08);
    wait_idle();
    n_cmp++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_at_zero got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    repeat (3) send(8'($urandom_range(8'h20, 8'hFF)));
    send(8'h08);
    wait_idle();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lfbs_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size() || cursor_x !== 6'd2 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_result got %0d writes cursor (%0d,%0d) want %0d writes cursor (2,0)",
               got_q.size(), cursor_x, cursor_y, exp_q.size());
    end
  endtask

  task automatic test_ff_color();
    int n = 0, base;
    logic [23:0] nfg, nbg;
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    send(8'h0A);
    in_valid = 1'b1; in_code = 8'h0C;
    while (!in_ready && n < 200) begin n++; @(negedge CLOCK_50); end
    base = exp_q.size();
    model_byte(8'h0C);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    n_cmp++;
    if (n != 64) begin n_fail++; $display("FAIL ff_holdoff got %0d cycles want 64", n); end
    repeat (100) @(negedge CLOCK_50);
    nfg = 24'($urandom); nbg = 24'($urandom);
    set_color = 1'b1; color_fg = nfg; color_bg = nbg;
    @(negedge CLOCK_50);
    set_color = 1'b0;
    mfg = nfg; mbg = nbg;
    for (int i = base + 100; i < exp_q.size(); i++) begin exp_q[i].fg = nfg; exp_q[i].bg = nbg; end
    wait_idle();
    send(8'h5A, 1'b1, 24'hFF0000, 24'h0000FF);
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size() || got_q[$] !== wr_t'{8'h5A, 6'd0, 5'd0, 24'hFF0000, 24'h0000FF}) begin
      n_fail++;
      $display("FAIL color_z got %0d writes last %h want %0d writes last Z@(0,0) FF0000/0000FF",
               got_q.size(), got_q[$], exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ffcol_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    int r;
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      b = r <= 5 ? 8'($urandom_range(8'h20, 8'hFF)) : r == 6 ? 8'h0D : r == 7 ? 8'h0A :
          r == 8 ? 8'h08 : 8'($urandom_range(8'h10, 8'h17));
      if ($urandom_range(0, 7) == 0) send(b, 1'b1, 24'($urandom), 24'($urandom));
      else send(b);
    end
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size() || cursor_x !== 6'(mx) || cursor_y !== 5'(my)) begin
      n_fail++;
      $display("FAIL rand_end got %0d writes cursor (%0d,%0d) want %0d writes cursor (%0d,%0d)",
               got_q.size(), cursor_x, cursor_y, exp_q.size(), mx, my);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    send(8'h0C);
    repeat (50) @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (charWr !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_drop got wr=%b cursor (%0d,%0d) want wr=0 (0,0)", charWr, cursor_x, cursor_y);
    end
    mx = 0; my = 0; mfg = 24'hFFFFFF; mbg = 24'h0;
    repeat (3) @(negedge CLOCK_50);
    got_q.delete(); exp_q.delete(); stamp_q.delete();
    push_screen();
    reset = 1'b0;
    wait_idle();
    n_cmp++;
    if (got_q.size() != 1536 || stamp_q[$] - stamp_q[0] != 1535) begin
      n_fail++;
      $display("FAIL midrst_count got %0d writes want 1536 consecutive", got_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_wr[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : wr_t'('0), exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_ab();
    test_wrap();
    test_lf_bs();
    test_ff_color();
    test_random_stream();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
